// File: rtl/sar_seq_ctrl_if.sv
// Comparator/DAC handshake bundle for the SAR sequencer.
// The slave modport is the sequencer side; the master modport drives the comparator and start inputs.
interface sar_seq_ctrl_if #(
  parameter int NBIT = 10
);
  logic            start;
  logic            rdy;
  logic            comp;
  logic            cks;
  logic            ckc;
  logic [NBIT-1:0] cf;
  logic [NBIT-1:0] dp;
  logic [NBIT-1:0] dn;
  logic [NBIT-1:0] dout;
  logic            done;
  logic            busy;
  logic            err;

  modport master (
    output start, rdy, comp,
    input  cks, ckc, cf, dp, dn, dout, done, busy, err
  );

  modport slave (
    input  start, rdy, comp,
    output cks, ckc, cf, dp, dn, dout, done, busy, err
  );
endinterface

// File: rtl/sar_seq_ctrl.sv
// Synchronous SAR conversion sequencer: sample, then one comparator trial per bit, MSB first.
// Optional WAIT timeout with sticky error flag is built when SAR_TIMEOUT_EN is defined.
module sar_seq_ctrl #(
  parameter int NBIT       = 10,
  parameter int SAMPLE_CYC = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic          clk,
  input  logic          rst,
  sar_seq_ctrl_if.slave bus
);
  localparam int TW = (NBIT > 1) ? $clog2(NBIT) : 1;
  localparam int SW = $clog2(SAMPLE_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_STROBE = 3'd2,
    S_WAIT   = 3'd3,
    S_RECOV  = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t          state_r;
  state_t          next_s;
  logic            rdy_q_r;
  logic [TW-1:0]   trial_r;
  logic [SW-1:0]   scnt_r;
  logic [NBIT-1:0] cf_r;
  logic [NBIT-1:0] dp_r;
  logic [NBIT-1:0] dn_r;
  logic [NBIT-1:0] dout_r;
  logic            cks_r;
  logic            ckc_r;
  logic            done_r;
  logic            busy_r;

  logic            rdy_rise_s;
  logic            decide_s;
  logic            timeout_s;
  logic            resolve_s;
  logic            bit_val_s;
  logic            accept_s;
  logic            last_trial_s;
  logic [TW-1:0]   bit_idx_s;

  // A level already high when WAIT is entered is not a decision; only a fresh edge counts.
  assign rdy_rise_s   = bus.rdy & ~rdy_q_r;
  assign decide_s     = (state_r == S_WAIT) & rdy_rise_s;
  assign resolve_s    = decide_s | timeout_s;
  assign bit_val_s    = decide_s & bus.comp;
  assign accept_s     = ((state_r == S_IDLE) | (state_r == S_FIN)) & bus.start;
  assign last_trial_s = (trial_r == TW'(NBIT - 1));
  assign bit_idx_s    = TW'(NBIT - 1) - trial_r;

`ifdef SAR_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wcnt_r;
  logic          err_r;

  // An edge arriving in the expiry cycle takes priority over the forced zero.
  assign timeout_s = (state_r == S_WAIT) & ~rdy_rise_s & (wcnt_r == WW'(TIMEOUT - 1));
  assign bus.err   = err_r;

  // Cycles spent in WAIT for the current trial.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_r <= WW'(0);
    end else if (state_r == S_WAIT) begin
      wcnt_r <= wcnt_r + WW'(1);
    end else begin
      wcnt_r <= WW'(0);
    end
  end

  // Sticky timeout flag, cleared when a new conversion is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (accept_s) begin
      err_r <= 1'b0;
    end else if (timeout_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end
`else
  assign timeout_s = 1'b0;
  assign bus.err   = 1'b0;

  if (TIMEOUT < 2) begin : g_timeout_out_of_range
  end
`endif

  // Next-state decode.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) next_s = S_SAMPLE;
        else           next_s = S_IDLE;
      end
      S_SAMPLE: begin
        if (scnt_r <= SW'(1)) next_s = S_STROBE;
        else                  next_s = S_SAMPLE;
      end
      S_STROBE: next_s = S_WAIT;
      S_WAIT: begin
        if (resolve_s) next_s = S_RECOV;
        else           next_s = S_WAIT;
      end
      S_RECOV: begin
        if (bus.rdy)           next_s = S_RECOV;
        else if (last_trial_s) next_s = S_FIN;
        else                   next_s = S_STROBE;
      end
      S_FIN: begin
        if (bus.start) next_s = S_SAMPLE;
        else           next_s = S_IDLE;
      end
      default: next_s = S_IDLE;
    endcase
  end

  // State register and comparator-ready history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      rdy_q_r <= 1'b0;
    end else begin
      state_r <= next_s;
      rdy_q_r <= bus.rdy;
    end
  end

  // Sample-window and trial counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt_r  <= SW'(0);
      trial_r <= TW'(0);
    end else if (accept_s) begin
      scnt_r  <= SW'(SAMPLE_CYC);
      trial_r <= TW'(0);
    end else begin
      if ((state_r == S_SAMPLE) && (scnt_r > SW'(1))) scnt_r <= scnt_r - SW'(1);
      if ((state_r == S_RECOV) && !bus.rdy && !last_trial_s) trial_r <= trial_r + TW'(1);
    end
  end

  // Per-trial result capture; DOUT keeps the previous code until overwritten bit by bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cf_r   <= {NBIT{1'b0}};
      dp_r   <= {NBIT{1'b0}};
      dn_r   <= {NBIT{1'b0}};
      dout_r <= {NBIT{1'b0}};
    end else if (accept_s) begin
      cf_r <= {NBIT{1'b0}};
      dp_r <= {NBIT{1'b0}};
      dn_r <= {NBIT{1'b0}};
    end else if (resolve_s) begin
      dout_r[bit_idx_s] <= bit_val_s;
      dp_r[bit_idx_s]   <= bit_val_s;
      dn_r[bit_idx_s]   <= ~bit_val_s;
      cf_r[trial_r]     <= 1'b1;
    end else begin
      dout_r <= dout_r;
    end
  end

  // Clock/strobe/status outputs registered from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cks_r  <= 1'b0;
      ckc_r  <= 1'b0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      cks_r  <= (next_s == S_STROBE) | (next_s == S_WAIT) | (next_s == S_RECOV);
      ckc_r  <= (next_s == S_STROBE) | (next_s == S_WAIT);
      done_r <= (next_s == S_FIN);
      busy_r <= (next_s != S_IDLE);
    end
  end

  assign bus.cks  = cks_r;
  assign bus.ckc  = ckc_r;
  assign bus.done = done_r;
  assign bus.busy = busy_r;
  assign bus.cf   = cf_r;
  assign bus.dp   = dp_r;
  assign bus.dn   = dn_r;
  assign bus.dout = dout_r;
endmodule
